soc_bringup_seq: RTL and testbench

//  Power-up sequencer that owns the soc_ctrl register port after reset. Per domain (sys_link, core_0, opt. core_1):

---
 rtl/soc_bringup_seq.sv | 209 ++++++++++++++++++++
 tb/tb_soc_bringup_seq.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_bringup_seq.sv
// Power-up sequencer: per domain gates clocks, programs and polls the PLL, then releases reset via soc_ctrl.
// Optional third domain (core_1) enabled by defining SOC_BRINGUP_SEQ_CORE1_EN.
module soc_bringup_seq #(
  parameter int unsigned            ADDR_WIDTH         = 8,
  parameter int unsigned            DATA_WIDTH         = 32,
  parameter logic [3:0]             SYS_REF_DIV        = 4'h1,
  parameter logic [11:0]            SYS_FB_DIV         = 12'd40,
  parameter logic [3:0]             CORE_REF_DIV       = 4'h1,
  parameter logic [11:0]            CORE_FB_DIV        = 12'd50,
  parameter int unsigned            POLL_INTERVAL      = 16,
  parameter int unsigned            LOCK_TIMEOUT       = 4096,
  parameter int unsigned            RST_HOLD_CYC       = 8,
  parameter logic [ADDR_WIDTH-1:0]  SYS_CLK_RST_ADDR   = ADDR_WIDTH'('h10),
  parameter logic [ADDR_WIDTH-1:0]  SYS_PLL_ADDR       = ADDR_WIDTH'('h14),
  parameter logic [ADDR_WIDTH-1:0]  CORE0_CLK_RST_ADDR = ADDR_WIDTH'('h20),
  parameter logic [ADDR_WIDTH-1:0]  CORE0_PLL_ADDR     = ADDR_WIDTH'('h24),
  parameter logic [ADDR_WIDTH-1:0]  CORE1_CLK_RST_ADDR = ADDR_WIDTH'('h30),
  parameter logic [ADDR_WIDTH-1:0]  CORE1_PLL_ADDR     = ADDR_WIDTH'('h34)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [1:0]              err_code_o,
  output logic [1:0]              err_dom_o,
  output logic                    host_gnt_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_waddr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic [1:0]              mem_wresp_i,
  output logic                    mem_re_o,
  output logic [ADDR_WIDTH-1:0]   mem_raddr_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic [1:0]              mem_rresp_i
);

  localparam int unsigned WMAX = (POLL_INTERVAL > RST_HOLD_CYC) ? POLL_INTERVAL : RST_HOLD_CYC;
  localparam int unsigned WCW  = $clog2(WMAX + 1);
  localparam int unsigned TW   = $clog2(LOCK_TIMEOUT + 1) + 1;
  localparam logic [WCW-1:0] POLL_LOAD = WCW'(POLL_INTERVAL - 1);
  localparam logic [WCW-1:0] HOLD_LOAD = WCW'(RST_HOLD_CYC - 1);
  localparam logic [TW-1:0]  TMO_LIM   = TW'(LOCK_TIMEOUT);
  localparam logic [DATA_WIDTH-1:0] SYS_PLL_WORD  = DATA_WIDTH'({SYS_FB_DIV, SYS_REF_DIV});
  localparam logic [DATA_WIDTH-1:0] CORE_PLL_WORD = DATA_WIDTH'({CORE_FB_DIV, CORE_REF_DIV});
  localparam logic [DATA_WIDTH-1:0] CLK_EN_WORD   = DATA_WIDTH'(2);
  localparam logic [DATA_WIDTH-1:0] REL_WORD      = DATA_WIDTH'(3);
`ifdef SOC_BRINGUP_SEQ_CORE1_EN
  localparam logic [1:0] LAST_DOM = 2'd2;
`else
  localparam logic [1:0] LAST_DOM = 2'd1;
`endif

  typedef enum logic [3:0] {
    S_IDLE, S_GATE, S_PLL_WR, S_LOCK_RD, S_LOCK_WAIT, S_CLK_EN, S_HOLD, S_REL, S_DONE, S_ERROR
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       dom_q, dom_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [1:0]       ecode_q, ecode_d;
  logic [1:0]       edom_q, edom_d;

  logic                  we_c, re_c, host_state;
  logic [ADDR_WIDTH-1:0] waddr_c, raddr_c, cr_addr, pll_addr;
  logic [DATA_WIDTH-1:0] wdata_c, pll_word;

  always_comb begin
    cr_addr  = SYS_CLK_RST_ADDR;
    pll_addr = SYS_PLL_ADDR;
    pll_word = SYS_PLL_WORD;
    case (dom_q)
      2'd1: begin
        cr_addr  = CORE0_CLK_RST_ADDR;
        pll_addr = CORE0_PLL_ADDR;
        pll_word = CORE_PLL_WORD;
      end
`ifdef SOC_BRINGUP_SEQ_CORE1_EN
      2'd2: begin
        cr_addr  = CORE1_CLK_RST_ADDR;
        pll_addr = CORE1_PLL_ADDR;
        pll_word = CORE_PLL_WORD;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      dom_q   <= '0;
      tmo_q   <= '0;
      wcnt_q  <= '0;
      ecode_q <= '0;
      edom_q  <= '0;
    end else begin
      state_q <= state_d;
      dom_q   <= dom_d;
      tmo_q   <= tmo_d;
      wcnt_q  <= wcnt_d;
      ecode_q <= ecode_d;
      edom_q  <= edom_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dom_d   = dom_q;
    tmo_d   = tmo_q;
    wcnt_d  = wcnt_q;
    ecode_d = ecode_q;
    edom_d  = edom_q;
    we_c    = 1'b0;
    re_c    = 1'b0;
    waddr_c = '0;
    wdata_c = '0;
    raddr_c = '0;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start_i) begin
          state_d = S_GATE;
          dom_d   = '0;
          ecode_d = '0;
          edom_d  = '0;
        end
      end
      S_GATE: begin
        we_c    = 1'b1;
        waddr_c = cr_addr;
        state_d = S_PLL_WR;
      end
      S_PLL_WR: begin
        we_c    = 1'b1;
        waddr_c = pll_addr;
        wdata_c = pll_word;
        tmo_d   = '0;
        state_d = S_LOCK_RD;
      end
      S_LOCK_RD: begin
        re_c    = 1'b1;
        raddr_c = pll_addr;
        if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
        if (mem_rdata_i[16]) begin
          state_d = S_CLK_EN;
        end else if (tmo_q >= TMO_LIM) begin
          state_d = S_ERROR;
          ecode_d = 2'b10;
          edom_d  = dom_q;
        end else begin
          state_d = S_LOCK_WAIT;
          wcnt_d  = POLL_LOAD;
        end
      end
      S_LOCK_WAIT: begin
        if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
        if (wcnt_q == '0) state_d = S_LOCK_RD;
        else              wcnt_d  = wcnt_q - 1'b1;
      end
      S_CLK_EN: begin
        we_c    = 1'b1;
        waddr_c = cr_addr;
        wdata_c = CLK_EN_WORD;
        state_d = S_HOLD;
        wcnt_d  = HOLD_LOAD;
      end
      S_HOLD: begin
        if (wcnt_q == '0) state_d = S_REL;
        else              wcnt_d  = wcnt_q - 1'b1;
      end
      S_REL: begin
        we_c    = 1'b1;
        waddr_c = cr_addr;
        wdata_c = REL_WORD;
        if (dom_q == LAST_DOM) begin
          state_d = S_DONE;
        end else begin
          dom_d   = dom_q + 1'b1;
          state_d = S_GATE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A bus error overrides any lock/timeout decision taken on the same access.
    if ((we_c && mem_wresp_i != 2'b00) || (re_c && mem_rresp_i != 2'b00)) begin
      state_d = S_ERROR;
      ecode_d = 2'b01;
      edom_d  = dom_q;
    end
  end

  assign host_state  = (state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_ERROR);
  assign busy_o      = !rst_i && !host_state;
  assign done_o      = !rst_i && (state_q == S_DONE);
  assign err_o       = !rst_i && (state_q == S_ERROR);
  assign err_code_o  = rst_i ? 2'b00 : ecode_q;
  assign err_dom_o   = rst_i ? 2'b00 : edom_q;
  assign host_gnt_o  = rst_i || (host_state && !start_i);
  assign mem_we_o    = we_c && !rst_i;
  assign mem_waddr_o = rst_i ? '0 : waddr_c;
  assign mem_wdata_o = rst_i ? '0 : wdata_c;
  assign mem_wstrb_o = '1;
  assign mem_re_o    = re_c && !rst_i;
  assign mem_raddr_o = rst_i ? '0 : raddr_c;

endmodule

// File: tb/tb_soc_bringup_seq.sv
// Directed bench for soc_bringup_seq: soc_ctrl register port modelled with per-domain PLL lock behaviour.
module tb_soc_bringup_seq;

`ifdef SOC_BRINGUP_SEQ_CORE1_EN
  localparam int N_DOM = 3;
`else
  localparam int N_DOM = 2;
`endif
  localparam int HOLD  = 8;
  localparam int POLL  = 16;
  localparam int PER   = 5 + HOLD;
  localparam int NEVER = 1 << 30;
  localparam int LOGSZ = 4096;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic       start_i = 1'b0;
  logic       busy_o, done_o, err_o, host_gnt_o;
  logic [1:0] err_code_o, err_dom_o;
  logic       mem_we_o, mem_re_o;
  logic [7:0] mem_waddr_o, mem_raddr_o;
  logic [31:0] mem_wdata_o, mem_rdata_i;
  logic [3:0] mem_wstrb_o;
  logic [1:0] mem_wresp_i, mem_rresp_i;

  soc_bringup_seq #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32),
    .SYS_REF_DIV(4'h1), .SYS_FB_DIV(12'd40), .CORE_REF_DIV(4'h1), .CORE_FB_DIV(12'd50),
    .POLL_INTERVAL(POLL), .LOCK_TIMEOUT(4096), .RST_HOLD_CYC(HOLD),
    .SYS_CLK_RST_ADDR(8'h10), .SYS_PLL_ADDR(8'h14),
    .CORE0_CLK_RST_ADDR(8'h20), .CORE0_PLL_ADDR(8'h24),
    .CORE1_CLK_RST_ADDR(8'h30), .CORE1_PLL_ADDR(8'h34)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .err_code_o(err_code_o), .err_dom_o(err_dom_o), .host_gnt_o(host_gnt_o),
    .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_wresp_i(mem_wresp_i),
    .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o), .mem_rdata_i(mem_rdata_i),
    .mem_rresp_i(mem_rresp_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_cnt[3];
  int lock_after[3];
  logic clr_rd = 1'b0;
  logic [7:0] bad_waddr = 8'hFF;

  int          log_n = 0;
  int          log_cyc [LOGSZ];
  logic        log_we  [LOGSZ];
  logic [7:0]  log_addr[LOGSZ];
  logic [31:0] log_data[LOGSZ];

  function automatic logic [7:0] cr_addr(input int d);
    return (d == 0) ? 8'h10 : (d == 1) ? 8'h20 : 8'h30;
  endfunction
  function automatic logic [7:0] pll_addr(input int d);
    return (d == 0) ? 8'h14 : (d == 1) ? 8'h24 : 8'h34;
  endfunction
  function automatic logic [31:0] pll_word(input int d);
    return (d == 0) ? 32'h0000_0281 : 32'h0000_0321;   // {fb=40,ref=1} / {fb=50,ref=1}
  endfunction
  function automatic int pll_dom(input logic [7:0] a);
    return (a == 8'h14) ? 0 : (a == 8'h24) ? 1 : (a == 8'h34) ? 2 : -1;
  endfunction

  // Register port model: lock bit set once a domain has seen lock_after[d] earlier reads.
  always @* begin
    mem_rdata_i = '0;
    mem_rresp_i = 2'b00;
    if (mem_re_o && pll_dom(mem_raddr_o) >= 0)
      if (rd_cnt[pll_dom(mem_raddr_o)] >= lock_after[pll_dom(mem_raddr_o)])
        mem_rdata_i[16] = 1'b1;
    mem_wresp_i = (mem_we_o && mem_waddr_o == bad_waddr) ? 2'b10 : 2'b00;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (clr_rd) begin
      for (int i = 0; i < 3; i++) rd_cnt[i] <= 0;
    end else if (mem_re_o && pll_dom(mem_raddr_o) >= 0) begin
      rd_cnt[pll_dom(mem_raddr_o)] <= rd_cnt[pll_dom(mem_raddr_o)] + 1;
    end
  end

  always @(negedge clk) begin
    if ((mem_we_o || mem_re_o) && log_n < LOGSZ) begin
      log_cyc[log_n]  = cyc;
      log_we[log_n]   = mem_we_o;
      log_addr[log_n] = mem_we_o ? mem_waddr_o : mem_raddr_o;
      log_data[log_n] = mem_we_o ? mem_wdata_o : 32'h0;
      log_n = log_n + 1;
    end
  end

  task automatic wait_flag(input bit want_err, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      if ((want_err ? err_o : done_o) === 1'b1) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic start_pulse(output int c0);
    @(negedge clk);
    start_i = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_o, done_o, err_o, mem_we_o, mem_re_o, host_gnt_o} !== 6'b000001) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000001", {busy_o, done_o, err_o, mem_we_o, mem_re_o, host_gnt_o});
    end
    rst_i = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy_o, done_o, err_o, mem_we_o, mem_re_o, host_gnt_o, err_code_o, err_dom_o} !== 10'b0000010000) begin
      n_fail++; $display("FAIL idle_flags: got %b expected 0000010000",
                         {busy_o, done_o, err_o, mem_we_o, mem_re_o, host_gnt_o, err_code_o, err_dom_o});
    end
    n_checks++;
    if ({mem_waddr_o, mem_raddr_o, mem_wdata_o} !== 48'h0 || mem_wstrb_o !== 4'hF) begin
      n_fail++; $display("FAIL idle_bus: got waddr %0h raddr %0h wdata %0h wstrb %0h expected 0 0 0 f",
                         mem_waddr_o, mem_raddr_o, mem_wdata_o, mem_wstrb_o);
    end
  endtask

  // Lock on first read; optionally a spurious start_i pulse mid-sequence that must be ignored.
  task automatic test_nominal(input string tag, input bit poke_busy);
    int c0, at, l0, idx, ofs, ewe;
    logic [7:0] ea;
    logic [31:0] ed;
    l0 = log_n;
    @(negedge clk);
    start_i = 1'b1;
    c0 = cyc;
    #1;
    n_checks++;
    if (host_gnt_o !== 1'b0) begin
      n_fail++; $display("FAIL %s gnt_on_start: got %b expected 0", tag, host_gnt_o);
    end
    @(negedge clk);
    start_i = 1'b0;
    n_checks++;
    if ({busy_o, host_gnt_o} !== 2'b10) begin
      n_fail++; $display("FAIL %s busy_gnt: got %b expected 10", tag, {busy_o, host_gnt_o});
    end
    if (poke_busy) begin
      repeat (9) @(negedge clk);
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
    end
    wait_flag(1'b0, 200, at);
    n_checks++;
    if (at - c0 !== 1 + N_DOM * PER) begin
      n_fail++; $display("FAIL %s done_latency: got %0d expected %0d", tag, at - c0, 1 + N_DOM * PER);
    end
    n_checks++;
    if ({busy_o, err_o, host_gnt_o} !== 3'b001) begin
      n_fail++; $display("FAIL %s done_flags: got %b expected 001", tag, {busy_o, err_o, host_gnt_o});
    end
    n_checks++;
    if (log_n - l0 !== 5 * N_DOM) begin
      n_fail++; $display("FAIL %s access_count: got %0d expected %0d", tag, log_n - l0, 5 * N_DOM);
    end
    for (int d = 0; d < N_DOM; d++) begin
      for (int s = 0; s < 5; s++) begin
        idx = l0 + d * 5 + s;
        ofs = (s == 4) ? 4 + HOLD : s;
        ewe = (s != 2) ? 1 : 0;
        ea  = (s == 1 || s == 2) ? pll_addr(d) : cr_addr(d);
        ed  = (s == 0) ? 32'h0 : (s == 1) ? pll_word(d) : (s == 3) ? 32'h2 : 32'h3;
        n_checks++;
        if (idx >= log_n || log_cyc[idx] !== c0 + 1 + d * PER + ofs || log_we[idx] !== ewe[0] ||
            log_addr[idx] !== ea || (ewe == 1 && log_data[idx] !== ed)) begin
          n_fail++;
          $display("FAIL %s access d%0d s%0d: got cyc %0d we %b addr %0h data %0h expected cyc %0d we %0d addr %0h data %0h",
                   tag, d, s, log_cyc[idx] - c0, log_we[idx], log_addr[idx], log_data[idx],
                   1 + d * PER + ofs, ewe, ea, ed);
        end
      end
    end
  endtask

  task automatic test_lock_poll();
    int c0, at, l0, nrd, prev;
    @(negedge clk); clr_rd = 1'b1;
    @(negedge clk); clr_rd = 1'b0;
    lock_after[1] = 3;
    l0 = log_n;
    start_pulse(c0);
    wait_flag(1'b0, 300, at);
    n_checks++;
    if (at - c0 !== 1 + N_DOM * PER + 3 * (1 + POLL)) begin
      n_fail++; $display("FAIL poll_latency: got %0d expected %0d", at - c0, 1 + N_DOM * PER + 3 * (1 + POLL));
    end
    nrd = 0;
    prev = -1;
    for (int i = l0; i < log_n; i++) begin
      if (!log_we[i] && log_addr[i] == 8'h24) begin
        if (prev >= 0) begin
          n_checks++;
          if (log_cyc[i] - prev !== 1 + POLL) begin
            n_fail++; $display("FAIL poll_spacing: got %0d expected %0d", log_cyc[i] - prev, 1 + POLL);
          end
        end
        prev = log_cyc[i];
        nrd++;
      end
    end
    n_checks++;
    if (nrd !== 4) begin
      n_fail++; $display("FAIL poll_reads: got %0d expected 4", nrd);
    end
    lock_after[1] = 0;
  endtask

  task automatic test_timeout();
    int c0, at, l0, nen, nrd;
    lock_after[0] = NEVER;
    l0 = log_n;
    start_pulse(c0);
    wait_flag(1'b1, 5000, at);
    // reads at cycle 3+17k see count 17k; first count >= 4096 is k=241 -> ERROR at 3+4097+1
    n_checks++;
    if (at - c0 !== 4101) begin
      n_fail++; $display("FAIL tmo_latency: got %0d expected 4101", at - c0);
    end
    n_checks++;
    if ({err_code_o, err_dom_o, host_gnt_o, busy_o, done_o} !== 7'b1000100) begin
      n_fail++; $display("FAIL tmo_flags: got %b expected 1000100", {err_code_o, err_dom_o, host_gnt_o, busy_o, done_o});
    end
    nen = 0;
    nrd = 0;
    for (int i = l0; i < log_n; i++) begin
      if (log_we[i] && log_data[i] == 32'h2) nen++;
      if (!log_we[i]) nrd++;
    end
    n_checks++;
    if (nen !== 0 || nrd !== 242) begin
      n_fail++; $display("FAIL tmo_accesses: got clk_en %0d reads %0d expected 0 242", nen, nrd);
    end
    lock_after[0] = 0;
  endtask

  task automatic test_slverr();
    int c0, at, l0;
    bad_waddr = 8'h24;
    l0 = log_n;
    start_pulse(c0);
    n_checks++;
    if (err_o !== 1'b0) begin
      n_fail++; $display("FAIL slv_err_cleared: got %b expected 0", err_o);
    end
    wait_flag(1'b1, 100, at);
    n_checks++;
    if (at - c0 !== 16) begin
      n_fail++; $display("FAIL slv_latency: got %0d expected 16", at - c0);
    end
    n_checks++;
    if ({err_code_o, err_dom_o, done_o, busy_o, host_gnt_o} !== 7'b0101001) begin
      n_fail++; $display("FAIL slv_flags: got %b expected 0101001", {err_code_o, err_dom_o, done_o, busy_o, host_gnt_o});
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (log_n - l0 !== 7 || log_cyc[log_n - 1] - c0 !== 15) begin
      n_fail++; $display("FAIL slv_accesses: got count %0d last %0d expected 7 15", log_n - l0, log_cyc[log_n - 1] - c0);
    end
    bad_waddr = 8'hFF;
  endtask

  task automatic test_reset_mid();
    int c0, l0;
    start_pulse(c0);
    while (cyc < c0 + 25) @(negedge clk);   // last HOLD cycle of core_0
    rst_i = 1'b1;
    l0 = log_n;
    #1;
    n_checks++;
    if ({mem_we_o, mem_re_o, busy_o, host_gnt_o} !== 4'b0001) begin
      n_fail++; $display("FAIL rst_cycle: got %b expected 0001", {mem_we_o, mem_re_o, busy_o, host_gnt_o});
    end
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    n_checks++;
    if ({busy_o, done_o, err_o, mem_we_o, mem_re_o, host_gnt_o, err_code_o, err_dom_o} !== 10'b0000010000) begin
      n_fail++; $display("FAIL rst_after: got %b expected 0000010000",
                         {busy_o, done_o, err_o, mem_we_o, mem_re_o, host_gnt_o, err_code_o, err_dom_o});
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (log_n !== l0) begin
      n_fail++; $display("FAIL rst_no_access: got %0d accesses expected 0", log_n - l0);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) lock_after[i] = 0;
    test_reset();
    test_nominal("nominal", 1'b0);
    test_lock_poll();
    test_timeout();
    test_slverr();
    test_reset_mid();
    test_nominal("restart", 1'b0);
    test_nominal("back_to_back", 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
